dwfifo_arbiter: RTL and testbench
=================================

Name: dwfifo_arbiter

Overview:
- Controller for the shared wide-in/narrow-out width-converting FIFO (INPUT_WIDTH words in, OUTPUT_WIDTH words out).
- Push side: packet-atomic round-robin arbitration of NUM_REQ producers onto the FIFO push port.
- Pop side: sequences FIFO pops around the one-cycle registered read latency and presents a valid/ready stream to one consumer at full throughput.

Parameters:
- NUM_REQ, 4, number of producers (2..16).
- INPUT_WIDTH, 8, producer/FIFO write word width.
- OUTPUT_WIDTH, 4, FIFO read/consumer word width; INPUT_WIDTH is an integer multiple.
- ID_WIDTH, 2, width of grant_id; equals clog2(NUM_REQ).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-producer word valid.
- req_last  in  NUM_REQ  per-producer last word of packet.
- req_data  in  NUM_REQ*INPUT_WIDTH  producer i data at bits [i*INPUT_WIDTH +: INPUT_WIDTH].
- req_ready  out  NUM_REQ  per-producer accept.
- grant_id  out  ID_WIDTH  index of the currently granted/locked producer.
- fifo_push  out  1  FIFO push.
- fifo_d  out  INPUT_WIDTH  FIFO write data.
- fifo_full  in  1  FIFO full.
- fifo_pop  out  1  FIFO pop (one OUTPUT_WIDTH word).
- fifo_q  in  OUTPUT_WIDTH  FIFO read data, valid the cycle after fifo_pop.
- fifo_empty  in  1  FIFO empty.
- out_valid  out  1  consumer data valid.
- out_data  out  OUTPUT_WIDTH  consumer data.
- out_ready  in  1  consumer accept.

Behaviour:
- Push FSM, states ARB and LOCK. Reset: ARB, rr_ptr=0, grant_id=0.
- ARB: grant = first i with req_valid[i], searching from rr_ptr upward with wrap.
- LOCK: grant = locked index; other producers see req_ready=0.
- req_ready[g] = (grant valid) && !fifo_full. Accept = req_valid[g] && req_ready[g].
- fifo_push = accept; fifo_d = req_data[g]. Combinational, same cycle.
- Accept with req_last=1: state goes to ARB and rr_ptr = g+1 mod NUM_REQ. Single-word packets stay in ARB.
- Accept with req_last=0 from ARB: state goes to LOCK on g.
- LOCK holds across fifo_full stalls and across req_valid gaps of the locked producer.
- No push is ever issued while fifo_full=1. No requester is granted when none is valid.
- grant_id is registered: the index of the last grant (LOCK index while locked).
- Pop side: 2-entry output buffer (occ 0..2) plus inflight flag (0/1).
- fifo_pop = !fifo_empty && (occ + inflight - (out_valid && out_ready)) < 2.
- inflight <= fifo_pop. When inflight=1, fifo_q is written into the buffer that cycle.
- out_valid = (occ != 0); out_data = oldest entry. Strict FIFO order.
- Full rate is one output word per cycle: the first word appears 2 cycles after fifo_empty deasserts.
- With out_ready held low, at most 2 words are drained from the FIFO (occ=2, inflight=0).
- Simultaneous capture and consumer drain in the same cycle keeps occ unchanged.
- Push and pop paths are fully independent; both may be active in the same cycle.
- Reset values: state=ARB, rr_ptr=0, grant_id=0, occ=0, inflight=0, all buffer entries 0, out_valid=0, fifo_push=0, fifo_pop=0, req_ready=0.
- rst asserted mid-packet or mid-read drops the lock and any inflight word; no output during the rst cycle. The FIFO is reset on the same rst.

Test Plan:
- After rst, all 4 producers assert req_valid with single-word packets (req_last=1), data 0x10+i -> fifo_d sequence 0x10,0x11,0x12,0x13,0x10, one push per cycle.
- Producer 1 sends a 3-word packet (0xA1,0xA2,0xA3 with last on 0xA3) while producer 2 is continuously valid -> pushes A1,A2,A3 contiguous, then producer 2; grant_id=1 throughout the packet.
- fifo_full=1 for 3 cycles in the middle of producer 0's packet -> req_ready=0 and fifo_push=0 for those cycles; LOCK retained; the packet resumes with no interleave.
- FIFO holds bytes 0x21,0x43 (ratio 2), out_ready=1 -> out_data 1,2,3,4 on consecutive cycles starting 2 cycles after the first fifo_pop.
- out_ready=0 with a non-empty FIFO -> exactly 2 fifo_pop pulses, then occ=2. out_ready raised -> words delivered in order with no loss or duplication.
- rst in the cycle after fifo_pop, mid-packet -> next cycle out_valid=0, state=ARB, grant_id=0, occ=0.

Source files
------------

// File: rtl/dwfifo_arbiter_if.sv
// Bus bundle for dwfifo_arbiter: producer request lanes, FIFO push/pop ports and consumer stream.
interface dwfifo_arbiter_if #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned INPUT_WIDTH  = 8,
  parameter int unsigned OUTPUT_WIDTH = 4,
  parameter int unsigned ID_WIDTH     = 2
);
  logic [NUM_REQ-1:0]             req_valid;
  logic [NUM_REQ-1:0]             req_last;
  logic [NUM_REQ*INPUT_WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]             req_ready;
  logic [ID_WIDTH-1:0]            grant_id;
  logic                           fifo_push;
  logic [INPUT_WIDTH-1:0]         fifo_d;
  logic                           fifo_full;
  logic                           fifo_pop;
  logic [OUTPUT_WIDTH-1:0]        fifo_q;
  logic                           fifo_empty;
  logic                           out_valid;
  logic [OUTPUT_WIDTH-1:0]        out_data;
  logic                           out_ready;

  // Controller side
  modport master (
    input  req_valid, req_last, req_data, fifo_full, fifo_q, fifo_empty, out_ready,
    output req_ready, grant_id, fifo_push, fifo_d, fifo_pop, out_valid, out_data
  );

  // Environment side: producers, FIFO and consumer
  modport slave (
    output req_valid, req_last, req_data, fifo_full, fifo_q, fifo_empty, out_ready,
    input  req_ready, grant_id, fifo_push, fifo_d, fifo_pop, out_valid, out_data
  );
endinterface

// File: rtl/dwfifo_arbiter.sv
// Controller for a shared wide-in/narrow-out FIFO: packet-atomic round-robin push arbitration
// and a full-throughput pop sequencer that hides the FIFO's one-cycle read latency.
module dwfifo_arbiter #(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned INPUT_WIDTH  = 8,
  parameter int unsigned OUTPUT_WIDTH = 4,
  parameter int unsigned ID_WIDTH     = 2
) (
  input  logic              clk,
  input  logic              rst,
  dwfifo_arbiter_if.master  bus_io
);

  typedef enum logic [0:0] {StArb, StLock} state_e;

  // Push side state
  state_e              state_q;
  logic [ID_WIDTH-1:0] rr_ptr_q;
  logic [ID_WIDTH-1:0] grant_id_q;

  logic                arb_found;
  logic [ID_WIDTH-1:0] arb_idx;
  logic [ID_WIDTH-1:0] cand;
  logic [ID_WIDTH-1:0] grant;
  logic                grant_valid;
  logic                accept;
  logic [ID_WIDTH-1:0] rr_next;

  // Pop side state
  logic [1:0]              occ_q, occ_d;
  logic                    inflight_q;
  logic [OUTPUT_WIDTH-1:0] buf_q [2];
  logic [OUTPUT_WIDTH-1:0] buf_d [2];
  logic                    drain;
  logic [2:0]              pending;
  logic                    pop;

  // Round-robin search: first valid requester at or above rr_ptr, wrapping.
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = ID_WIDTH'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!arb_found && bus_io.req_valid[cand]) begin
        arb_found = 1'b1;
        arb_idx   = cand;
      end
    end
  end

  // Grant selection and push handshake; everything is held off while rst is high.
  always_comb begin
    grant       = (state_q == StLock) ? grant_id_q : arb_idx;
    grant_valid = (state_q == StLock) || arb_found;
    rr_next     = ID_WIDTH'((32'(grant) + 1) % NUM_REQ);
    bus_io.req_ready = '0;
    if (!rst && grant_valid && !bus_io.fifo_full) begin
      bus_io.req_ready[grant] = 1'b1;
    end
    accept           = bus_io.req_valid[grant] && bus_io.req_ready[grant];
    bus_io.fifo_push = accept;
    bus_io.fifo_d    = bus_io.req_data[32'(grant)*INPUT_WIDTH +: INPUT_WIDTH];
  end

  // Push FSM: lock onto a producer after a non-last word, release and advance rr_ptr on last.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StArb;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
    end else begin
      if (state_q == StArb && arb_found) begin
        grant_id_q <= arb_idx;
      end
      if (accept) begin
        if (bus_io.req_last[grant]) begin
          state_q  <= StArb;
          rr_ptr_q <= rr_next;
        end else begin
          state_q  <= StLock;
        end
      end
    end
  end

  assign bus_io.grant_id = grant_id_q;

  // Pop issue: only pop when the word arriving next cycle is guaranteed a buffer slot.
  always_comb begin
    drain   = (occ_q != 2'd0) && bus_io.out_ready;
    pending = {1'b0, occ_q} + {2'b00, inflight_q} - {2'b00, drain};
    pop     = !rst && !bus_io.fifo_empty && (pending < 3'd2);
  end

  assign bus_io.fifo_pop  = pop;
  assign bus_io.out_valid = (occ_q != 2'd0);
  assign bus_io.out_data  = buf_q[0];

  // Output buffer next state: entry 0 is oldest; drain shifts, capture appends behind.
  always_comb begin
    buf_d = buf_q;
    occ_d = occ_q;
    if (drain) begin
      buf_d[0] = buf_q[1];
      occ_d    = occ_q - 2'd1;
    end
    // Capture cannot see occ_d == 2: an inflight word always had a slot reserved.
    if (inflight_q) begin
      buf_d[occ_d[0]] = bus_io.fifo_q;
      occ_d           = occ_d + 2'd1;
    end
  end

  // Pop-side registers; rst drops any inflight word.
  always_ff @(posedge clk) begin
    if (rst) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
      buf_q[0]   <= '0;
      buf_q[1]   <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= pop;
      buf_q      <= buf_d;
    end
  end

endmodule

// File: tb/tb_dwfifo_arbiter.sv
// Directed bench for dwfifo_arbiter with a small read-latency FIFO model on the pop side.
module tb_dwfifo_arbiter;

  logic clk = 1'b0;
  logic rst;

  int n_checks = 0;
  int n_fail   = 0;

  logic [3:0] mem [0:63];
  int         rd_idx = 0;
  int         wr_idx = 0;
  int         pops;
  int         got;

  dwfifo_arbiter_if #(
    .NUM_REQ(4), .INPUT_WIDTH(8), .OUTPUT_WIDTH(4), .ID_WIDTH(2)
  ) bus ();

  dwfifo_arbiter #(
    .NUM_REQ(4), .INPUT_WIDTH(8), .OUTPUT_WIDTH(4), .ID_WIDTH(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_io (bus)
  );

  always #5 clk = ~clk;

  // FIFO read port model: data appears the cycle after a pop; cleared by rst.
  assign bus.fifo_empty = (rd_idx == wr_idx);
  always @(posedge clk) begin
    if (rst) begin
      rd_idx <= wr_idx;
    end else if (bus.fifo_pop) begin
      bus.fifo_q <= mem[rd_idx];
      rd_idx     <= rd_idx + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic set_data(input int i, input logic [7:0] d);
    bus.req_data[i*8 +: 8] = d;
  endtask

  task automatic load_word(input logic [3:0] w);
    mem[wr_idx] = w;
    wr_idx      = wr_idx + 1;
  endtask

  initial begin
    rst            = 1'b1;
    bus.req_valid  = 4'hF;
    bus.req_last   = 4'hF;
    bus.req_data   = '0;
    bus.fifo_full  = 1'b0;
    bus.out_ready  = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_grant_id", 32'(bus.grant_id), 0);
    check_eq("rst_out_valid", 32'(bus.out_valid), 0);
    check_eq("rst_fifo_push", 32'(bus.fifo_push), 0);
    check_eq("rst_fifo_pop", 32'(bus.fifo_pop), 0);
    check_eq("rst_req_ready", 32'(bus.req_ready), 0);
    check_eq("rst_out_data", 32'(bus.out_data), 0);

    // Single-word packets from all producers rotate 0,1,2,3,0
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_data(i, 8'h10 + 8'(i));
    for (int k = 0; k < 5; k++) begin
      #1;
      check_eq("rr_push", 32'(bus.fifo_push), 1);
      check_eq("rr_data", 32'(bus.fifo_d), 32'h10 + 32'(k % 4));
      check_eq("rr_grant_id", 32'(bus.grant_id), (k == 0) ? 0 : 32'((k - 1) % 4));
      @(negedge clk);
    end

    // Producer 1 three-word packet while producer 2 waits (rr_ptr is 1)
    bus.req_valid = 4'b0110;
    bus.req_last  = 4'b0100;
    set_data(1, 8'hA1);
    set_data(2, 8'h55);
    #1;
    check_eq("pkt_a1", 32'(bus.fifo_d), 32'hA1);
    check_eq("pkt_a1_ready", 32'(bus.req_ready), 32'b0010);
    @(negedge clk);
    set_data(1, 8'hA2);
    #1;
    check_eq("pkt_a2", 32'(bus.fifo_d), 32'hA2);
    check_eq("pkt_a2_ready", 32'(bus.req_ready), 32'b0010);
    check_eq("pkt_a2_grant", 32'(bus.grant_id), 1);
    @(negedge clk);
    set_data(1, 8'hA3);
    bus.req_last = 4'b0110;
    #1;
    check_eq("pkt_a3", 32'(bus.fifo_d), 32'hA3);
    check_eq("pkt_a3_push", 32'(bus.fifo_push), 1);
    check_eq("pkt_a3_grant", 32'(bus.grant_id), 1);
    @(negedge clk);
    set_data(1, 8'hA4);
    #1;
    check_eq("pkt_p2", 32'(bus.fifo_d), 32'h55);
    check_eq("pkt_p2_ready", 32'(bus.req_ready), 32'b0100);
    @(negedge clk);

    // Producer 0 packet with a 3-cycle full stall and a valid gap; producer 3 competing
    bus.req_valid = 4'b0001;
    bus.req_last  = 4'b1000;
    set_data(0, 8'hB1);
    set_data(3, 8'hC3);
    #1;
    check_eq("stall_b1", 32'(bus.fifo_d), 32'hB1);
    check_eq("stall_b1_push", 32'(bus.fifo_push), 1);
    @(negedge clk);
    bus.fifo_full = 1'b1;
    bus.req_valid = 4'b1001;
    set_data(0, 8'hB2);
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("stall_push", 32'(bus.fifo_push), 0);
      check_eq("stall_ready", 32'(bus.req_ready), 0);
      check_eq("stall_grant", 32'(bus.grant_id), 0);
      @(negedge clk);
    end
    bus.fifo_full = 1'b0;
    bus.req_valid = 4'b1000;
    #1;
    check_eq("gap_push", 32'(bus.fifo_push), 0);
    check_eq("gap_ready", 32'(bus.req_ready), 32'b0001);
    @(negedge clk);
    bus.req_valid = 4'b1001;
    #1;
    check_eq("resume_b2", 32'(bus.fifo_d), 32'hB2);
    check_eq("resume_b2_push", 32'(bus.fifo_push), 1);
    @(negedge clk);
    set_data(0, 8'hB3);
    bus.req_last = 4'b1001;
    #1;
    check_eq("resume_b3", 32'(bus.fifo_d), 32'hB3);
    @(negedge clk);
    bus.req_valid = 4'b1000;
    #1;
    check_eq("after_c3", 32'(bus.fifo_d), 32'hC3);
    check_eq("after_c3_ready", 32'(bus.req_ready), 32'b1000);
    @(negedge clk);
    bus.req_valid = 4'b0000;

    // Pop stream at full rate: bytes 0x21,0x43 -> nibbles 1,2,3,4
    bus.out_ready = 1'b1;
    load_word(4'h1); load_word(4'h2); load_word(4'h3); load_word(4'h4);
    #1;
    check_eq("pop_first", 32'(bus.fifo_pop), 1);
    check_eq("pop_lat0", 32'(bus.out_valid), 0);
    @(negedge clk);
    #1;
    check_eq("pop_lat1", 32'(bus.out_valid), 0);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      #1;
      check_eq("stream_valid", 32'(bus.out_valid), 1);
      check_eq("stream_data", 32'(bus.out_data), 32'(k + 1));
      @(negedge clk);
    end
    #1;
    check_eq("stream_end", 32'(bus.out_valid), 0);

    // Backpressure: exactly 2 pops, then ordered delivery
    bus.out_ready = 1'b0;
    load_word(4'h5); load_word(4'h6); load_word(4'h7); load_word(4'h8);
    pops = 0;
    for (int k = 0; k < 6; k++) begin
      #1;
      if (bus.fifo_pop) pops++;
      @(negedge clk);
    end
    check_eq("bp_pops", 32'(pops), 2);
    #1;
    check_eq("bp_valid", 32'(bus.out_valid), 1);
    check_eq("bp_head", 32'(bus.out_data), 5);
    bus.out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 12 && got < 4; c++) begin
      #1;
      if (bus.out_valid) begin
        check_eq("bp_data", 32'(bus.out_data), 32'(5 + got));
        got++;
      end
      @(negedge clk);
    end
    check_eq("bp_count", 32'(got), 4);
    #1;
    check_eq("bp_drained", 32'(bus.out_valid), 0);

    // Reset mid-packet and mid-read
    @(negedge clk);
    bus.out_ready = 1'b0;
    load_word(4'h9); load_word(4'hA);
    bus.req_valid = 4'b0100;
    bus.req_last  = 4'b0000;
    set_data(2, 8'hD1);
    #1;
    check_eq("mid_pop", 32'(bus.fifo_pop), 1);
    check_eq("mid_push", 32'(bus.fifo_d), 32'hD1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("mid_grant", 32'(bus.grant_id), 2);
    check_eq("rstcyc_push", 32'(bus.fifo_push), 0);
    check_eq("rstcyc_pop", 32'(bus.fifo_pop), 0);
    check_eq("rstcyc_ready", 32'(bus.req_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    bus.req_valid = 4'b0110;
    bus.req_last  = 4'b0110;
    set_data(1, 8'hE1);
    set_data(2, 8'hD2);
    #1;
    check_eq("post_out_valid", 32'(bus.out_valid), 0);
    check_eq("post_grant_id", 32'(bus.grant_id), 0);
    check_eq("post_pop", 32'(bus.fifo_pop), 0);
    check_eq("post_push_data", 32'(bus.fifo_d), 32'hE1);
    check_eq("post_ready", 32'(bus.req_ready), 32'b0010);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
